// File: rtl/pinmux_pkg.sv
// Shared pin-mode encoding and register byte addresses for the configurable pinmux.
// No logic and no latency here.
// Backpressure: not applicable.
package pinmux_pkg;

    typedef enum logic [1:0] {
        MODE_DIS = 2'b00,
        MODE_GPI = 2'b01,
        MODE_PER = 2'b10,
        MODE_GPO = 2'b11
    } mode_e;

    localparam logic [5:0] ADDR_MODE0       = 6'h00;
    localparam logic [5:0] ADDR_MODE1       = 6'h04;
    localparam logic [5:0] ADDR_MODE2       = 6'h08;
    localparam logic [5:0] ADDR_MODE3       = 6'h0C;
    localparam logic [5:0] ADDR_GPIO_OUT_LO = 6'h10;
    localparam logic [5:0] ADDR_GPIO_OUT_HI = 6'h14;
    localparam logic [5:0] ADDR_GPIO_IN_LO  = 6'h18;
    localparam logic [5:0] ADDR_GPIO_IN_HI  = 6'h1C;
    localparam logic [5:0] ADDR_IRQ_STAT_LO = 6'h20;
    localparam logic [5:0] ADDR_IRQ_STAT_HI = 6'h24;
    localparam logic [5:0] ADDR_IRQ_EN_LO   = 6'h28;
    localparam logic [5:0] ADDR_IRQ_EN_HI   = 6'h2C;

endpackage

// File: rtl/pinmux_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the mclk domain.
// Latency: SYNC_STG mclk cycles.
// Backpressure: none, samples every cycle.
module pinmux_sync #(
    parameter int NPIN     = 38,
    parameter int SYNC_STG = 2
) (
    input  logic            mclk,
    input  logic            h_reset_n,
    input  logic [NPIN-1:0] d,
    output logic [NPIN-1:0] q
);

    logic [NPIN-1:0] stg [SYNC_STG];

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            for (int i = 0; i < SYNC_STG; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < SYNC_STG; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[SYNC_STG-1];

endmodule

// File: rtl/pinmux_cfg.sv
// Register-programmable pinmux: per-pin DIS/GPI/PER/GPO select, GPIO data, edge IRQs, break-before-make.
// Latency: register ack one cycle after reg_cs; pad drive is combinational from registered state.
// Backpressure: reg_cs is held until reg_ack; ack drops for a cycle between back-to-back accesses.
module pinmux_cfg
    import pinmux_pkg::*;
#(
    parameter int                NPIN     = 38,
    parameter int                SYNC_STG = 2,
    parameter logic [2*NPIN-1:0] MODE_RST = {NPIN{2'b10}}
) (
    input  logic            mclk,
    input  logic            h_reset_n,
    input  logic            reg_cs,
    input  logic            reg_wr,
    input  logic [5:0]      reg_addr,
    input  logic [3:0]      reg_be,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            reg_ack,
    input  logic [NPIN-1:0] periph_out,
    input  logic [NPIN-1:0] periph_oeb,
    output logic [NPIN-1:0] periph_in,
    input  logic [NPIN-1:0] io_in,
    output logic [NPIN-1:0] io_out,
    output logic [NPIN-1:0] io_oeb,
    output logic            irq
);

    logic [2*NPIN-1:0] mode_q, mode_d;
    logic [NPIN-1:0]   gpo_q, gpo_d, en_q, en_d, stat_q, stat_d, guard_q, guard_d;
    logic [NPIN-1:0]   sync_q, sync_qq, rise;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, acc, wr_en;
    logic [3:0]        word;
    logic [127:0]      mode_pad;
    logic [63:0]       gpo_pad, gpi_pad, stat_pad, en_pad;
    logic              unused_ok;

    pinmux_sync #(.NPIN(NPIN), .SYNC_STG(SYNC_STG)) u_sync (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .d         (io_in),
        .q         (sync_q)
    );

    // A new access is only accepted while ack is low, which forces the idle cycle between acks.
    assign acc       = reg_cs & ~ack_q;
    assign wr_en     = acc & reg_wr;
    assign word      = reg_addr[5:2];
    assign unused_ok = ^reg_addr[1:0];

    assign mode_pad = 128'(mode_q);
    assign gpo_pad  = 64'(gpo_q);
    assign gpi_pad  = 64'(sync_q);
    assign stat_pad = 64'(stat_q);
    assign en_pad   = 64'(en_q);

    always_comb begin
        rdata_d = '0;
        case (word)
            ADDR_MODE0[5:2]:       rdata_d = mode_pad[31:0];
            ADDR_MODE1[5:2]:       rdata_d = mode_pad[63:32];
            ADDR_MODE2[5:2]:       rdata_d = mode_pad[95:64];
            ADDR_MODE3[5:2]:       rdata_d = mode_pad[127:96];
            ADDR_GPIO_OUT_LO[5:2]: rdata_d = gpo_pad[31:0];
            ADDR_GPIO_OUT_HI[5:2]: rdata_d = gpo_pad[63:32];
            ADDR_GPIO_IN_LO[5:2]:  rdata_d = gpi_pad[31:0];
            ADDR_GPIO_IN_HI[5:2]:  rdata_d = gpi_pad[63:32];
            ADDR_IRQ_STAT_LO[5:2]: rdata_d = stat_pad[31:0];
            ADDR_IRQ_STAT_HI[5:2]: rdata_d = stat_pad[63:32];
            ADDR_IRQ_EN_LO[5:2]:   rdata_d = en_pad[31:0];
            ADDR_IRQ_EN_HI[5:2]:   rdata_d = en_pad[63:32];
            default:               rdata_d = '0;
        endcase
    end

    // Edge detect on synchronised inputs, plus per-pin pad steering with the guard overriding everything.
    always_comb begin
        rise      = '0;
        io_oeb    = '1;
        io_out    = '0;
        periph_in = '0;
        for (int p = 0; p < NPIN; p++) begin
            rise[p] = sync_q[p] & ~sync_qq[p] & (mode_q[2*p +: 2] == MODE_GPI);
            if (!guard_q[p]) begin
                case (mode_e'(mode_q[2*p +: 2]))
                    MODE_PER: begin
                        io_oeb[p]    = periph_oeb[p];
                        io_out[p]    = periph_out[p];
                        periph_in[p] = io_in[p];
                    end
                    MODE_GPO: begin
                        io_oeb[p] = 1'b0;
                        io_out[p] = gpo_q[p];
                    end
                    default: ;
                endcase
            end
        end
    end

    // A fresh edge in the same cycle as its W1C keeps the status bit set.
    always_comb begin
        mode_d  = mode_q;
        gpo_d   = gpo_q;
        en_d    = en_q;
        stat_d  = stat_q | rise;
        guard_d = '0;
        for (int p = 0; p < NPIN; p++) begin
            if (wr_en && word == ADDR_MODE0[5:2] + 4'(p / 16) && reg_be[(p % 16) / 4]) begin
                mode_d[2*p +: 2] = reg_wdata[2*(p % 16) +: 2];
                guard_d[p]       = (reg_wdata[2*(p % 16) +: 2] != mode_q[2*p +: 2]);
            end
            if (wr_en && word == ADDR_GPIO_OUT_LO[5:2] + 4'(p / 32) && reg_be[(p % 32) / 8])
                gpo_d[p] = reg_wdata[p % 32];
            if (wr_en && word == ADDR_IRQ_EN_LO[5:2] + 4'(p / 32) && reg_be[(p % 32) / 8])
                en_d[p] = reg_wdata[p % 32];
            if (wr_en && word == ADDR_IRQ_STAT_LO[5:2] + 4'(p / 32) && reg_be[(p % 32) / 8]
                && reg_wdata[p % 32])
                stat_d[p] = rise[p];
        end
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            mode_q  <= MODE_RST;
            gpo_q   <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            guard_q <= '0;
            sync_qq <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            mode_q  <= mode_d;
            gpo_q   <= gpo_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            guard_q <= guard_d;
            sync_qq <= sync_q;
            ack_q   <= acc;
            rdata_q <= (acc && !reg_wr) ? rdata_d : '0;
        end
    end

    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;
    assign irq       = |(stat_q & en_q);

endmodule

// File: tb/tb_pinmux_cfg.sv
// Directed bench for pinmux_cfg: register table plus hand sequences for guard, IRQ race and reset.
module tb_pinmux_cfg;

    localparam int NPIN = 38;

    logic            mclk = 1'b0;
    logic            h_reset_n;
    logic            reg_cs, reg_wr;
    logic [5:0]      reg_addr;
    logic [3:0]      reg_be;
    logic [31:0]     reg_wdata, reg_rdata;
    logic            reg_ack, irq;
    logic [NPIN-1:0] periph_out, periph_oeb, periph_in, io_in, io_out, io_oeb;

    int checks   = 0;
    int failures = 0;

    pinmux_cfg dut (
        .mclk       (mclk),
        .h_reset_n  (h_reset_n),
        .reg_cs     (reg_cs),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_be     (reg_be),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .periph_out (periph_out),
        .periph_oeb (periph_oeb),
        .periph_in  (periph_in),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq        (irq)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accepting posedge.
    task automatic reg_access(input logic wr, input logic [5:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rd);
        if (reg_ack) @(negedge mclk);
        reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_be = be; reg_wdata = wd;
        @(posedge mclk);
        @(negedge mclk);
        chk("ack", {63'd0, reg_ack}, 64'd1);
        rd = reg_rdata;
        reg_cs = 1'b0; reg_wr = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        h_reset_n  = 1'b0;
        reg_cs     = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_be = '0; reg_wdata = '0;
        periph_oeb = 38'h15_A5A5_0000;
        periph_out = 38'h2A_3C3C_F0F0;
        io_in      = 38'h0A_1234_0F0F;

        tbl[0]  = '{1'b0, 6'h00, 4'hF, 32'h0,         32'hAAAA_AAAA};
        tbl[1]  = '{1'b0, 6'h08, 4'hF, 32'h0,         32'h0000_0AAA};
        tbl[2]  = '{1'b0, 6'h0C, 4'hF, 32'h0,         32'h0000_0000};
        tbl[3]  = '{1'b0, 6'h10, 4'hF, 32'h0,         32'h0000_0000};
        tbl[4]  = '{1'b0, 6'h28, 4'hF, 32'h0,         32'h0000_0000};
        tbl[5]  = '{1'b0, 6'h18, 4'hF, 32'h0,         32'h1234_0F0F};
        tbl[6]  = '{1'b0, 6'h1C, 4'hF, 32'h0,         32'h0000_000A};
        tbl[7]  = '{1'b1, 6'h14, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{1'b0, 6'h14, 4'hF, 32'h0,         32'h0000_003F};
        tbl[9]  = '{1'b1, 6'h28, 4'h3, 32'h1234_5678, 32'h0};
        tbl[10] = '{1'b0, 6'h28, 4'hF, 32'h0,         32'h0000_5678};
        tbl[11] = '{1'b1, 6'h18, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 6'h18, 4'hF, 32'h0,         32'h1234_0F0F};
        tbl[13] = '{1'b1, 6'h30, 4'hF, 32'hFFFF_FFFF, 32'h0};

        // Reset state
        repeat (3) @(negedge mclk);
        chk("rst_ack", {63'd0, reg_ack}, 64'd0);
        chk("rst_rdata", {32'd0, reg_rdata}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        h_reset_n = 1'b1;
        repeat (4) @(negedge mclk);
        chk("rst_io_oeb", 64'(io_oeb), 64'(periph_oeb));
        chk("rst_io_out", 64'(io_out), 64'(periph_out));
        chk("rst_periph_in", 64'(periph_in), 64'(io_in));

        // Register table
        for (int i = 0; i < 14; i++) begin
            reg_access(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, rd);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), {32'd0, rd}, {32'd0, tbl[i].exp});
        end
        reg_access(1'b1, 6'h14, 4'hF, 32'h0, rd);
        reg_access(1'b1, 6'h28, 4'hF, 32'h0, rd);

        // GPO with break-before-make guard
        reg_access(1'b1, 6'h10, 4'hF, 32'h0000_0008, rd);
        chk("pre_oeb3", {63'd0, io_oeb[3]}, 64'd0);
        reg_access(1'b1, 6'h00, 4'h1, 32'h0000_00C0, rd);
        chk("guard_oeb3", {63'd0, io_oeb[3]}, 64'd1);
        chk("guard_out3", {63'd0, io_out[3]}, 64'd0);
        @(negedge mclk);
        chk("gpo_oeb3", {63'd0, io_oeb[3]}, 64'd0);
        chk("gpo_out3", {63'd0, io_out[3]}, 64'd1);
        chk("other_oeb20", {63'd0, io_oeb[20]}, {63'd0, periph_oeb[20]});
        chk("other_out20", {63'd0, io_out[20]}, {63'd0, periph_out[20]});

        // Same-mode rewrite of pin3 (pins 4..15 go PER->DIS)
        reg_access(1'b1, 6'h00, 4'hF, 32'h0000_00C0, rd);
        chk("rewrite_oeb3", {63'd0, io_oeb[3]}, 64'd0);
        chk("rewrite_out3", {63'd0, io_out[3]}, 64'd1);
        @(negedge mclk);
        chk("rewrite_oeb3_n", {63'd0, io_oeb[3]}, 64'd0);
        chk("dis_oeb12", {63'd0, io_oeb[12]}, 64'd1);

        // DIS pin 12: periph_in held low while pad toggles; PER pin 20 passes through unsynchronised
        for (int i = 0; i < 4; i++) begin
            io_in[12] = ~io_in[12];
            io_in[20] = ~io_in[20];
            #1;
            chk("dis_periph_in12", {63'd0, periph_in[12]}, 64'd0);
            chk("per_periph_in20", {63'd0, periph_in[20]}, {63'd0, io_in[20]});
            @(negedge mclk);
        end
        reg_access(1'b0, 6'h20, 4'hF, 32'h0, rd);
        chk("stat_lo_nongpi", {32'd0, rd}, 64'd0);

        // IRQ on pin 36
        reg_access(1'b1, 6'h08, 4'h2, 32'h0000_0100, rd);
        reg_access(1'b0, 6'h08, 4'hF, 32'h0, rd);
        chk("mode2_gpi", {32'd0, rd}, 64'h0000_01AA);
        reg_access(1'b1, 6'h2C, 4'hF, 32'h0000_0010, rd);
        reg_access(1'b0, 6'h24, 4'hF, 32'h0, rd);
        chk("stat_hi_idle", {32'd0, rd}, 64'd0);
        io_in[36] = 1'b1;
        @(posedge mclk); @(posedge mclk); @(negedge mclk);
        chk("irq_early", {63'd0, irq}, 64'd0);
        @(negedge mclk);
        chk("irq_set", {63'd0, irq}, 64'd1);
        reg_access(1'b0, 6'h24, 4'hF, 32'h0, rd);
        chk("stat_hi_set", {32'd0, rd}, 64'h10);
        reg_access(1'b1, 6'h24, 4'hF, 32'h0000_0010, rd);
        chk("irq_clr", {63'd0, irq}, 64'd0);
        reg_access(1'b0, 6'h24, 4'hF, 32'h0, rd);
        chk("stat_hi_clr", {32'd0, rd}, 64'd0);

        // W1C landing on the same edge as a new rising edge
        io_in[36] = 1'b0;
        repeat (4) @(negedge mclk);
        io_in[36] = 1'b1;
        @(posedge mclk); @(posedge mclk); @(negedge mclk);
        reg_access(1'b1, 6'h24, 4'hF, 32'h0000_0010, rd);
        chk("race_irq", {63'd0, irq}, 64'd1);
        reg_access(1'b0, 6'h24, 4'hF, 32'h0, rd);
        chk("race_stat_hi", {32'd0, rd}, 64'h10);

        // Reset asserted during a write
        @(negedge mclk);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 6'h10; reg_be = 4'hF; reg_wdata = 32'hFFFF_FFFF;
        #2 h_reset_n = 1'b0;
        @(posedge mclk); #1;
        chk("rst_mid_ack", {63'd0, reg_ack}, 64'd0);
        @(negedge mclk);
        reg_cs = 1'b0; reg_wr = 1'b0;
        chk("rst_mid_irq", {63'd0, irq}, 64'd0);
        h_reset_n = 1'b1;
        @(negedge mclk);
        chk("rst_mid_oeb", 64'(io_oeb), 64'(periph_oeb));
        reg_access(1'b0, 6'h00, 4'hF, 32'h0, rd);
        chk("rst_mid_mode0", {32'd0, rd}, 64'hAAAA_AAAA);
        reg_access(1'b0, 6'h10, 4'hF, 32'h0, rd);
        chk("rst_mid_gpo", {32'd0, rd}, 64'd0);
        reg_access(1'b0, 6'h2C, 4'hF, 32'h0, rd);
        chk("rst_mid_en_hi", {32'd0, rd}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
